// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state enumeration and default widths.
package mips_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned MD_CNT_W = 6;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIXUP,
      ST_DONE
   } md_state_t;

   // MULT and DIV are the signed forms; bit 1 separates divide from multiply.
   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_datapath.sv
// Iterative magnitude datapath: radix-2 shift-add multiply or restoring
// shift-subtract divide, one iteration per i_step.
module md_datapath #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_div,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic             r_div;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;

   // One extra bit catches the multiply carry and the divide borrow.
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      w_shift = {r_hi, r_lo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_m};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div <= 1'b0;
         r_m   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
      end else if (i_load) begin
         r_div <= i_div;
         r_hi  <= '0;
         r_m   <= i_div ? i_b : i_a;
         r_lo  <= i_div ? i_a : i_b;
      end else if (i_step) begin
         if (r_div) begin
            if (!w_diff[WIDTH]) begin
               r_hi <= w_diff[WIDTH-1:0];
               r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
               r_hi <= w_shift[WIDTH-1:0];
               r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
         end
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: FSM, sign handling, architectural HI/LO
// registers and MTHI/MTLO writes around the iterative md_datapath.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned CNT_W = MD_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic             hiWrite,
   input  logic             loWrite,
   input  logic [WIDTH-1:0] writeData,
   output logic             busy,
   output logic             done,
   output logic             divByZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_t        r_state;
   md_state_t        w_next;

   logic [CNT_W-1:0] r_cnt;
   logic             r_is_div;
   logic             r_neg_a;
   logic             r_neg_b;
   logic             r_zero_b;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_load;
   logic             w_step;
   logic             w_last;
   logic             w_neg_a_in;
   logic             w_neg_b_in;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH-1:0] w_dp_hi;
   logic [WIDTH-1:0] w_dp_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;

   always_comb begin
      w_neg_a_in = op_is_signed(op) & operandA[WIDTH-1];
      w_neg_b_in = op_is_signed(op) & operandB[WIDTH-1];
      w_mag_a    = w_neg_a_in ? -operandA : operandA;
      w_mag_b    = w_neg_b_in ? -operandB : operandB;
      w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_step    = 1'b0;
      busy      = (r_state != ST_IDLE);
      done      = (r_state == ST_DONE);
      divByZero = (r_state == ST_DONE) & r_is_div & r_zero_b;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_next = ST_FIXUP;
            end
         end
         ST_FIXUP: w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_zero_b <= 1'b0;
      end else if (w_load) begin
         r_cnt    <= '0;
         r_is_div <= op_is_div(op);
         r_neg_a  <= w_neg_a_in;
         r_neg_b  <= w_neg_b_in;
         r_zero_b <= (operandB == '0);
      end else if (w_step) begin
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   md_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_div  (op_is_div(op)),
      .i_step (w_step),
      .i_a    (w_mag_a),
      .i_b    (w_mag_b),
      .o_hi   (w_dp_hi),
      .o_lo   (w_dp_lo)
   );

   // Sign flags are only ever set for signed ops, so unsigned results pass through.
   always_comb begin
      w_prod = {w_dp_hi, w_dp_lo};
      if (r_neg_a ^ r_neg_b) begin
         w_prod = -w_prod;
      end
      w_quot   = (r_neg_a ^ r_neg_b) ? -w_dp_lo : w_dp_lo;
      w_rem    = r_neg_a ? -w_dp_hi : w_dp_hi;
      w_res_hi = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == ST_FIXUP) begin
         if (!(r_is_div && r_zero_b)) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
      end else if (r_state == ST_IDLE) begin
         if (hiWrite) begin
            r_hi <= writeData;
         end
         if (loWrite) begin
            r_lo <= writeData;
         end
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit downstream of the register file.
- Consumes rs/rt read data (readData1/readData2) for MULT, MULTU, DIV and DIVU, and owns the architectural HI and LO registers.
- Also services MTHI/MTLO writes; MFHI/MFLO read the hi/lo outputs directly.
- Multi-cycle: the control path stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operandA  input  WIDTH  rs value: multiplicand or dividend.
- operandB  input  WIDTH  rt value: multiplier or divisor.
- hiWrite  input  1  MTHI strobe.
- loWrite  input  1  MTLO strobe.
- writeData  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- divByZero  output  1  pulses together with done when a DIV/DIVU had a zero divisor.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low at a clk edge, any state, including mid-operation):
  - state IDLE, counter 0.
  - hi, lo, busy, done, divByZero all 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch |operandA| and |operandB|: two's-complement magnitude for signed ops, raw value for unsigned ops.
  - Latch the sign flags and zero-divisor flag.
  - counter=0, next state RUN.
- RUN:
  - One iteration per cycle for exactly WIDTH cycles (E1..E32); counter increments each cycle; leave to FIXUP when counter==WIDTH-1.
  - Multiply: radix-2 shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIXUP (edge E33):
  - Signed multiply: negate the 64-bit product if the operand signs differ; HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder. Signed divide negates the quotient if signs differ and gives the remainder the sign of the dividend.
  - Divisor zero: HI/LO unchanged; set divByZero.
  - Next state DONE.
- DONE (cycle after E33):
  - done=1 (and divByZero if flagged) for exactly this one cycle, then IDLE at E34.
  - start is ignored in DONE.
- Latency: start sampled at E0 → hi/lo valid after E33 → done high in cycle E33..E34 → new start accepted at E34.
- busy: 1 from E0+ through E34−.
- start while busy: ignored. Operands are not re-sampled during RUN, so rs/rt may change freely.
- hiWrite/loWrite:
  - Honoured only in IDLE; ignored while busy.
  - Same edge as start in IDLE: the write lands at that edge, and the later result overwrites it.
  - hiWrite and loWrite together: both registers are written with writeData.
- Wrap cases:
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no flag.
  - MULT 0x80000000 * 0x80000000: HI=0x40000000, LO=0.
- Invalid op encodings: none; all four are defined.

Decomposition:
- Shared package mips_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - the state enumeration.
  - the WIDTH default constant.
- One natural sub-module: md_datapath. It holds the product/remainder shift register and the add/subtract step, with a per-cycle step input and mode select.
- The FSM, counter, sign handling, HI/LO registers and MTHI/MTLO logic stay in mult_div_unit.

Test Plan:
- Reset, then MULTU A=4, B=1 → busy for 34 cycles; done pulses once; HI=0x00000000, LO=0x00000004.
- MULT A=0xFFFFFFFF, B=0x00000011 → HI=0xFFFFFFFF, LO=0xFFFFFFEF. Then DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU A=17, B=0 → after 34 cycles, done and divByZero pulse together; HI/LO keep their previous values.
- DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. Then MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- MTHI 0x12345678 in IDLE → hi updates next edge. Second start and a loWrite=1 issued during RUN → both ignored; the final result is that of the first op only.
- rst_n low at RUN cycle 10 of a MULTU → next edge: busy=0, hi=lo=0, no done pulse. A fresh start is then accepted and completes normally.
